// File: rtl/id_ex_stage_if.sv
// Decode-to-execute pipeline boundary: ID-side inputs, EX-side registered outputs,
// and the pipeline control signals Hold, Flush, Stall and BubbleCount.
interface id_ex_stage_if #(parameter int NBits = 32);
  logic             Hold;
  logic             Flush;
  logic             ID_Valid;
  logic [10:0]      ID_Ctrl;
  logic [NBits-1:0] ID_ReadData1;
  logic [NBits-1:0] ID_ReadData2;
  logic [NBits-1:0] ID_Imm;
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic [4:0]       ID_Rd;

  logic             EX_Valid;
  logic [10:0]      EX_Ctrl;
  logic [NBits-1:0] EX_ReadData1;
  logic [NBits-1:0] EX_ReadData2;
  logic [NBits-1:0] EX_Imm;
  logic [4:0]       EX_Rs;
  logic [4:0]       EX_Rt;
  logic [4:0]       EX_Rd;
  logic             Stall;
  logic [15:0]      BubbleCount;

  modport master (
    output Hold, Flush, ID_Valid, ID_Ctrl, ID_ReadData1, ID_ReadData2, ID_Imm,
           ID_Rs, ID_Rt, ID_Rd,
    input  EX_Valid, EX_Ctrl, EX_ReadData1, EX_ReadData2, EX_Imm,
           EX_Rs, EX_Rt, EX_Rd, Stall, BubbleCount
  );

  modport slave (
    input  Hold, Flush, ID_Valid, ID_Ctrl, ID_ReadData1, ID_ReadData2, ID_Imm,
           ID_Rs, ID_Rt, ID_Rd,
    output EX_Valid, EX_Ctrl, EX_ReadData1, EX_ReadData2, EX_Imm,
           EX_Rs, EX_Rt, EX_Rd, Stall, BubbleCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush handling (remembered across Hold) and a saturating bubble counter.
module id_ex_stage #(
  parameter int NBits = 32
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  logic             exValid;
  logic [10:0]      exCtrl;
  logic [NBits-1:0] exReadData1;
  logic [NBits-1:0] exReadData2;
  logic [NBits-1:0] exImm;
  logic [4:0]       exRs;
  logic [4:0]       exRt;
  logic [4:0]       exRd;
  logic [15:0]      bubbleCnt;
  logic             flushPending;

  logic usesRt;
  logic hazard;
  logic kill;

  always_comb begin
    usesRt = bus.ID_Ctrl[10] | bus.ID_Ctrl[5] | bus.ID_Ctrl[4] | bus.ID_Ctrl[3];
    hazard = bus.ID_Valid & exValid & exCtrl[6] & exCtrl[7] & (exRt != 5'd0) &
             ((exRt == bus.ID_Rs) | (usesRt & (exRt == bus.ID_Rt)));
    kill   = bus.Flush | flushPending;
  end

  // A pending or current flush makes the stall pointless: the dependent op dies anyway.
  assign bus.Stall = hazard & ~bus.Hold & ~bus.Flush & ~flushPending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exValid      <= 1'b0;
      exCtrl       <= 11'd0;
      exReadData1  <= '0;
      exReadData2  <= '0;
      exImm        <= '0;
      exRs         <= 5'd0;
      exRt         <= 5'd0;
      exRd         <= 5'd0;
      bubbleCnt    <= 16'd0;
      flushPending <= 1'b0;
    end else if (bus.Hold) begin
      flushPending <= flushPending | bus.Flush;
    end else begin
      exReadData1 <= bus.ID_ReadData1;
      exReadData2 <= bus.ID_ReadData2;
      exImm       <= bus.ID_Imm;
      exRs        <= bus.ID_Rs;
      exRt        <= bus.ID_Rt;
      exRd        <= bus.ID_Rd;
      if (kill) begin
        exValid      <= 1'b0;
        exCtrl       <= 11'd0;
        flushPending <= 1'b0;
      end else if (hazard) begin
        exValid <= 1'b0;
        exCtrl  <= 11'd0;
        if (bubbleCnt != 16'hFFFF) bubbleCnt <= bubbleCnt + 16'd1;
      end else begin
        exValid <= bus.ID_Valid;
        exCtrl  <= bus.ID_Valid ? bus.ID_Ctrl : 11'd0;
      end
    end
  end

  assign bus.EX_Valid     = exValid;
  assign bus.EX_Ctrl      = exCtrl;
  assign bus.EX_ReadData1 = exReadData1;
  assign bus.EX_ReadData2 = exReadData2;
  assign bus.EX_Imm       = exImm;
  assign bus.EX_Rs        = exRs;
  assign bus.EX_Rt        = exRt;
  assign bus.EX_Rd        = exRd;
  assign bus.BubbleCount  = bubbleCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load, load-use bubble, false-stall cases,
// flush priority, flush held across Hold, async reset and counter saturation.
module tb_id_ex_stage;
  localparam int NB = 32;
  localparam logic [10:0] CtrlLw   = 11'b01111000000;
  localparam logic [10:0] CtrlAdd  = 11'b10010000010;
  localparam logic [10:0] CtrlAddi = 11'b01010000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          nChecks = 0;
  int          nFails = 0;
  logic [15:0] expCnt = 16'd0;

  id_ex_stage_if #(.NBits(NB)) bus ();
  id_ex_stage #(.NBits(NB)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic setId(input logic v, input logic [10:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] base);
    bus.ID_Valid     = v;
    bus.ID_Ctrl      = c;
    bus.ID_Rs        = rs;
    bus.ID_Rt        = rt;
    bus.ID_Rd        = rd;
    bus.ID_ReadData1 = base;
    bus.ID_ReadData2 = base + 32'd1;
    bus.ID_Imm       = base + 32'd2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One lw (rt=8) followed by a dependent add: exactly one bubble.
  task automatic doBubble();
    @(negedge clk); setId(1'b1, CtrlLw, 5'd4, 5'd8, 5'd0, 32'h1000);
    step();
    @(negedge clk); setId(1'b1, CtrlAdd, 5'd8, 5'd3, 5'd9, 32'h2000);
    step();
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    nChecks++; if (bus.EX_Valid !== 1'b0) begin nFails++; $display("FAIL reset_valid got %b exp 0", bus.EX_Valid); end
    nChecks++; if (bus.EX_Ctrl !== 11'd0) begin nFails++; $display("FAIL reset_ctrl got %h exp 0", bus.EX_Ctrl); end
    nChecks++; if (bus.BubbleCount !== 16'd0) begin nFails++; $display("FAIL reset_cnt got %h exp 0", bus.BubbleCount); end
    nChecks++; if (bus.Stall !== 1'b0) begin nFails++; $display("FAIL reset_stall got %b exp 0", bus.Stall); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_load();
    @(negedge clk); setId(1'b1, CtrlAdd, 5'd1, 5'd2, 5'd3, 32'h100);
    step();
    nChecks++; if (bus.EX_Valid !== 1'b1) begin nFails++; $display("FAIL load_valid got %b exp 1", bus.EX_Valid); end
    nChecks++; if (bus.EX_Ctrl !== CtrlAdd) begin nFails++; $display("FAIL load_ctrl got %h exp %h", bus.EX_Ctrl, CtrlAdd); end
    nChecks++; if (bus.EX_ReadData1 !== 32'h100) begin nFails++; $display("FAIL load_rd1 got %h exp 100", bus.EX_ReadData1); end
    nChecks++; if (bus.EX_ReadData2 !== 32'h101) begin nFails++; $display("FAIL load_rd2 got %h exp 101", bus.EX_ReadData2); end
    nChecks++; if (bus.EX_Imm !== 32'h102) begin nFails++; $display("FAIL load_imm got %h exp 102", bus.EX_Imm); end
    nChecks++; if ({bus.EX_Rs, bus.EX_Rt, bus.EX_Rd} !== {5'd1, 5'd2, 5'd3}) begin nFails++; $display("FAIL load_regs got %h exp %h", {bus.EX_Rs, bus.EX_Rt, bus.EX_Rd}, {5'd1, 5'd2, 5'd3}); end
    @(negedge clk); setId(1'b0, CtrlLw, 5'd4, 5'd5, 5'd6, 32'h200);
    step();
    nChecks++; if (bus.EX_Valid !== 1'b0) begin nFails++; $display("FAIL invalid_valid got %b exp 0", bus.EX_Valid); end
    nChecks++; if (bus.EX_Ctrl !== 11'd0) begin nFails++; $display("FAIL invalid_ctrl got %h exp 0", bus.EX_Ctrl); end
    nChecks++; if (bus.EX_ReadData1 !== 32'h200) begin nFails++; $display("FAIL invalid_rd1 got %h exp 200", bus.EX_ReadData1); end
  endtask

  task automatic test_load_use();
    @(negedge clk); setId(1'b1, CtrlLw, 5'd4, 5'd8, 5'd0, 32'h300);
    step();
    @(negedge clk); setId(1'b1, CtrlAdd, 5'd8, 5'd3, 5'd9, 32'h400);
    #1;
    nChecks++; if (bus.Stall !== 1'b1) begin nFails++; $display("FAIL lu_stall got %b exp 1", bus.Stall); end
    step();
    expCnt = expCnt + 16'd1;
    nChecks++; if (bus.EX_Valid !== 1'b0) begin nFails++; $display("FAIL lu_bubble_valid got %b exp 0", bus.EX_Valid); end
    nChecks++; if (bus.EX_Ctrl !== 11'd0) begin nFails++; $display("FAIL lu_bubble_ctrl got %h exp 0", bus.EX_Ctrl); end
    nChecks++; if (bus.BubbleCount !== expCnt) begin nFails++; $display("FAIL lu_cnt got %h exp %h", bus.BubbleCount, expCnt); end
    nChecks++; if (bus.EX_Rs !== 5'd8) begin nFails++; $display("FAIL lu_bubble_rs got %h exp 8", bus.EX_Rs); end
    nChecks++; if (bus.Stall !== 1'b0) begin nFails++; $display("FAIL lu_stall_drop got %b exp 0", bus.Stall); end
    step();
    nChecks++; if (bus.EX_Valid !== 1'b1) begin nFails++; $display("FAIL lu_resume_valid got %b exp 1", bus.EX_Valid); end
    nChecks++; if (bus.EX_Ctrl !== CtrlAdd) begin nFails++; $display("FAIL lu_resume_ctrl got %h exp %h", bus.EX_Ctrl, CtrlAdd); end
  endtask

  task automatic test_no_false_stall();
    @(negedge clk); setId(1'b1, CtrlLw, 5'd4, 5'd0, 5'd0, 32'h500);
    step();
    @(negedge clk); setId(1'b1, CtrlAdd, 5'd0, 5'd0, 5'd7, 32'h600);
    #1;
    nChecks++; if (bus.Stall !== 1'b0) begin nFails++; $display("FAIL r0_stall got %b exp 0", bus.Stall); end
    step();
    nChecks++; if (bus.EX_Valid !== 1'b1) begin nFails++; $display("FAIL r0_valid got %b exp 1", bus.EX_Valid); end
    nChecks++; if (bus.BubbleCount !== expCnt) begin nFails++; $display("FAIL r0_cnt got %h exp %h", bus.BubbleCount, expCnt); end
    @(negedge clk); setId(1'b1, CtrlLw, 5'd4, 5'd8, 5'd0, 32'h700);
    step();
    @(negedge clk); setId(1'b1, CtrlAddi, 5'd9, 5'd8, 5'd0, 32'h800);
    #1;
    nChecks++; if (bus.Stall !== 1'b0) begin nFails++; $display("FAIL addi_stall got %b exp 0", bus.Stall); end
    step();
    nChecks++; if (bus.EX_Ctrl !== CtrlAddi) begin nFails++; $display("FAIL addi_ctrl got %h exp %h", bus.EX_Ctrl, CtrlAddi); end
    nChecks++; if (bus.BubbleCount !== expCnt) begin nFails++; $display("FAIL addi_cnt got %h exp %h", bus.BubbleCount, expCnt); end
  endtask

  task automatic test_flush_vs_hazard();
    @(negedge clk); setId(1'b1, CtrlLw, 5'd4, 5'd8, 5'd0, 32'h900);
    step();
    @(negedge clk); setId(1'b1, CtrlAdd, 5'd8, 5'd1, 5'd2, 32'hA00); bus.Flush = 1'b1;
    #1;
    nChecks++; if (bus.Stall !== 1'b0) begin nFails++; $display("FAIL fh_stall got %b exp 0", bus.Stall); end
    step();
    nChecks++; if (bus.EX_Valid !== 1'b0) begin nFails++; $display("FAIL fh_valid got %b exp 0", bus.EX_Valid); end
    nChecks++; if (bus.BubbleCount !== expCnt) begin nFails++; $display("FAIL fh_cnt got %h exp %h", bus.BubbleCount, expCnt); end
    nChecks++; if (bus.EX_ReadData1 !== 32'hA00) begin nFails++; $display("FAIL fh_rd1 got %h exp a00", bus.EX_ReadData1); end
    @(negedge clk); bus.Flush = 1'b0;
    step();
    nChecks++; if (bus.EX_Valid !== 1'b1) begin nFails++; $display("FAIL fh_resume got %b exp 1", bus.EX_Valid); end
  endtask

  task automatic test_flush_during_hold();
    @(negedge clk); setId(1'b1, CtrlLw, 5'd4, 5'd8, 5'd0, 32'hB00);
    step();
    @(negedge clk); setId(1'b1, CtrlAdd, 5'd8, 5'd1, 5'd2, 32'hC00);
    bus.Hold = 1'b1; bus.Flush = 1'b1;
    #1;
    nChecks++; if (bus.Stall !== 1'b0) begin nFails++; $display("FAIL hold_stall got %b exp 0", bus.Stall); end
    for (int i = 0; i < 3; i++) begin
      step();
      nChecks++; if ({bus.EX_Valid, bus.EX_Ctrl} !== {1'b1, CtrlLw}) begin nFails++; $display("FAIL hold_frozen_%0d got %h exp %h", i, {bus.EX_Valid, bus.EX_Ctrl}, {1'b1, CtrlLw}); end
      nChecks++; if (bus.EX_ReadData1 !== 32'hB00) begin nFails++; $display("FAIL hold_rd1_%0d got %h exp b00", i, bus.EX_ReadData1); end
      nChecks++; if (bus.BubbleCount !== expCnt) begin nFails++; $display("FAIL hold_cnt_%0d got %h exp %h", i, bus.BubbleCount, expCnt); end
      @(negedge clk); bus.Flush = 1'b0;
    end
    bus.Hold = 1'b0;
    #1;
    nChecks++; if (bus.Stall !== 1'b0) begin nFails++; $display("FAIL pend_stall got %b exp 0", bus.Stall); end
    step();
    nChecks++; if (bus.EX_Valid !== 1'b0) begin nFails++; $display("FAIL pend_kill got %b exp 0", bus.EX_Valid); end
    nChecks++; if (bus.EX_Ctrl !== 11'd0) begin nFails++; $display("FAIL pend_ctrl got %h exp 0", bus.EX_Ctrl); end
    nChecks++; if (bus.BubbleCount !== expCnt) begin nFails++; $display("FAIL pend_cnt got %h exp %h", bus.BubbleCount, expCnt); end
    step();
    nChecks++; if (bus.EX_Valid !== 1'b1) begin nFails++; $display("FAIL pend_cleared got %b exp 1", bus.EX_Valid); end
  endtask

  task automatic test_reset_mid();
    while (expCnt < 16'd5) begin
      doBubble();
      expCnt = expCnt + 16'd1;
    end
    @(negedge clk); setId(1'b1, CtrlAdd, 5'd1, 5'd2, 5'd3, 32'hD00);
    step();
    nChecks++; if ({bus.EX_Valid, bus.BubbleCount} !== {1'b1, 16'd5}) begin nFails++; $display("FAIL pre_reset got %h exp %h", {bus.EX_Valid, bus.BubbleCount}, {1'b1, 16'd5}); end
    @(negedge clk); bus.Hold = 1'b1; bus.Flush = 1'b1;
    #2 reset = 1'b0;
    #1;
    nChecks++; if ({bus.EX_Valid, bus.EX_Ctrl} !== 12'd0) begin nFails++; $display("FAIL rst_mid_vc got %h exp 0", {bus.EX_Valid, bus.EX_Ctrl}); end
    nChecks++; if ({bus.EX_ReadData1, bus.EX_ReadData2, bus.EX_Imm} !== 96'd0) begin nFails++; $display("FAIL rst_mid_data got %h exp 0", {bus.EX_ReadData1, bus.EX_ReadData2, bus.EX_Imm}); end
    nChecks++; if ({bus.EX_Rs, bus.EX_Rt, bus.EX_Rd} !== 15'd0) begin nFails++; $display("FAIL rst_mid_regs got %h exp 0", {bus.EX_Rs, bus.EX_Rt, bus.EX_Rd}); end
    nChecks++; if (bus.BubbleCount !== 16'd0) begin nFails++; $display("FAIL rst_mid_cnt got %h exp 0", bus.BubbleCount); end
    step();
    nChecks++; if (bus.EX_Valid !== 1'b0) begin nFails++; $display("FAIL rst_hold_edge got %b exp 0", bus.EX_Valid); end
    @(negedge clk); reset = 1'b1; bus.Hold = 1'b0; bus.Flush = 1'b0;
    setId(1'b1, CtrlAdd, 5'd5, 5'd6, 5'd7, 32'hE00);
    expCnt = 16'd0;
    step();
    nChecks++; if ({bus.EX_Valid, bus.EX_Ctrl} !== {1'b1, CtrlAdd}) begin nFails++; $display("FAIL post_reset_load got %h exp %h", {bus.EX_Valid, bus.EX_Ctrl}, {1'b1, CtrlAdd}); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      doBubble();
      expCnt = expCnt + 16'd1;
    end
    nChecks++; if (bus.BubbleCount !== 16'd3) begin nFails++; $display("FAIL sat_low got %h exp 3", bus.BubbleCount); end
    // Preload the counter near the top instead of running ~131k cycles of bubbles.
    @(negedge clk);
    force dut.bubbleCnt = 16'hFFFD;
    #1 release dut.bubbleCnt;
    #1;
    expCnt = 16'hFFFD;
    nChecks++; if (bus.BubbleCount !== expCnt) begin nFails++; $display("FAIL sat_preload got %h exp %h", bus.BubbleCount, expCnt); end
    for (int i = 0; i < 4; i++) begin
      doBubble();
      expCnt = (expCnt == 16'hFFFF) ? 16'hFFFF : expCnt + 16'd1;
      nChecks++; if (bus.BubbleCount !== expCnt) begin nFails++; $display("FAIL sat_%0d got %h exp %h", i, bus.BubbleCount, expCnt); end
    end
  endtask

  initial begin
    bus.Hold = 1'b0;
    bus.Flush = 1'b0;
    setId(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    test_reset();
    test_load();
    test_load_use();
    test_no_false_stall();
    test_flush_vs_hazard();
    test_flush_during_hold();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
